// File: rtl/rf_param.sv
// rf_param: parametrised 2R/1W register file with registered reads,
// write bypass, post-reset clear sweep and a hlt-triggered dump port.
module rf_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    p0_addr,
  input  logic [AW-1:0]    p1_addr,
  input  logic             re0,
  input  logic             re1,
  output logic [WIDTH-1:0] p0,
  output logic [WIDTH-1:0] p1,
  input  logic [AW-1:0]    dst_addr,
  input  logic [WIDTH-1:0] dst,
  input  logic             we,
  input  logic             hlt,
  output logic             ready,
  output logic             dump_valid,
  output logic [AW-1:0]    dump_addr,
  output logic [WIDTH-1:0] dump_data
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FIRST = ZR ? AW'(1) : '0;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    DUMP,
    HALTED
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic hlt_q;
  logic hlt_edge;
  logic clearing;
  logic running;
  logic dumping;
  logic wr_acc;
  logic [WIDTH-1:0] rd0, rd1;
  logic [WIDTH-1:0] mem [DEPTH];

  assign hlt_edge = hlt && !hlt_q;
  assign clearing = (state_q == CLEAR);
  assign running  = (state_q == RUN);
  assign dumping  = (state_q == DUMP);
  assign wr_acc   = running && we && !(ZR && dst_addr == '0);

  // next-state and shared clear/dump pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST) state_d = RUN;
      end
      RUN: begin
        if (hlt_edge) begin
          state_d = DUMP;
          ptr_d   = FIRST;
        end
      end
      DUMP: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST) state_d = HALTED;
      end
      HALTED: begin
        if (!hlt) state_d = RUN;
      end
      default: state_d = CLEAR;
    endcase
  end

  // state, pointer and halt-edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hlt_q   <= hlt;
    end
  end

  // storage: zeroed by the sweep, then written from writeback
  always_ff @(posedge clk) begin
    if (clearing) mem[ptr_q] <= '0;
    else if (wr_acc) mem[dst_addr] <= dst;
  end

  // port 0 read data with bypass of the accepted write
  always_comb begin
    rd0 = mem[p0_addr];
    if (wr_acc && dst_addr == p0_addr) rd0 = dst;
    if (clearing || (ZR && p0_addr == '0)) rd0 = '0;
  end

  // port 1 read data with bypass of the accepted write
  always_comb begin
    rd1 = mem[p1_addr];
    if (wr_acc && dst_addr == p1_addr) rd1 = dst;
    if (clearing || (ZR && p1_addr == '0)) rd1 = '0;
  end

  // registered read ports; a disabled port holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0 <= '0;
      p1 <= '0;
    end else begin
      if (re0) p0 <= rd0;
      if (re1) p1 <= rd1;
    end
  end

  // ready flag and registered dump stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready      <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
    end else begin
      if (clearing && ptr_q == LAST) ready <= 1'b1;
      dump_valid <= dumping;
      if (dumping) begin
        dump_addr <= ptr_q;
        dump_data <= mem[ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: directed scoreboard bench for rf_param in two
// configurations (16x16 with zero register, 32x32 without).
module tb_rf_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, re0_a, re1_a, we_a, hlt_a;
  logic [3:0]  p0_addr_a, p1_addr_a, dst_addr_a, dump_addr_a;
  logic [15:0] dst_a, p0_a, p1_a, dump_data_a;
  logic        ready_a, dump_valid_a;

  logic        rst_b, re0_b, re1_b, we_b, hlt_b;
  logic [4:0]  p0_addr_b, p1_addr_b, dst_addr_b, dump_addr_b;
  logic [31:0] dst_b, p0_b, p1_b, dump_data_b;
  logic        ready_b, dump_valid_b;

  rf_param #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1)) u_a (
    .clk(clk), .rst_n(rst_a),
    .p0_addr(p0_addr_a), .p1_addr(p1_addr_a),
    .re0(re0_a), .re1(re1_a),
    .p0(p0_a), .p1(p1_a),
    .dst_addr(dst_addr_a), .dst(dst_a),
    .we(we_a), .hlt(hlt_a),
    .ready(ready_a), .dump_valid(dump_valid_a),
    .dump_addr(dump_addr_a), .dump_data(dump_data_a)
  );

  rf_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) u_b (
    .clk(clk), .rst_n(rst_b),
    .p0_addr(p0_addr_b), .p1_addr(p1_addr_b),
    .re0(re0_b), .re1(re1_b),
    .p0(p0_b), .p1(p1_b),
    .dst_addr(dst_addr_b), .dst(dst_b),
    .we(we_b), .hlt(hlt_b),
    .ready(ready_b), .dump_valid(dump_valid_b),
    .dump_addr(dump_addr_b), .dump_data(dump_data_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.v);
    end
  endtask

  task automatic rd_a(input logic [3:0] a0, input logic [3:0] a1,
                      input logic [15:0] e0, input logic [15:0] e1,
                      input string tag);
    p0_addr_a = a0;
    p1_addr_a = a1;
    re0_a = 1'b1;
    re1_a = 1'b1;
    push({tag, "_p0"}, 32'(e0));
    push({tag, "_p1"}, 32'(e1));
    tick();
    pop_chk(32'(p0_a));
    pop_chk(32'(p1_a));
  endtask

  task automatic rd_b(input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input string tag);
    p0_addr_b = a0;
    p1_addr_b = a1;
    re0_b = 1'b1;
    re1_b = 1'b1;
    push({tag, "_p0"}, e0);
    push({tag, "_p1"}, e1);
    tick();
    pop_chk(p0_b);
    pop_chk(p1_b);
  endtask

  initial begin
    rst_a = 1'b0; re0_a = 1'b0; re1_a = 1'b0; we_a = 1'b0; hlt_a = 1'b0;
    p0_addr_a = '0; p1_addr_a = '0; dst_addr_a = '0; dst_a = '0;
    rst_b = 1'b0; re0_b = 1'b0; re1_b = 1'b0; we_b = 1'b0; hlt_b = 1'b1;
    p0_addr_b = '0; p1_addr_b = '0; dst_addr_b = '0; dst_b = '0;

    repeat (3) tick();
    chk("rst_p0", 32'(p0_a), 32'h0);
    chk("rst_p1", 32'(p1_a), 32'h0);
    chk("rst_ready", 32'(ready_a), 32'h0);
    chk("rst_dump_valid", 32'(dump_valid_a), 32'h0);
    chk("rst_dump_addr", 32'(dump_addr_a), 32'h0);
    chk("rst_dump_data", 32'(dump_data_a), 32'h0);
    chk("rst_b_ready", 32'(ready_b), 32'h0);

    rst_a = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("clear_ready_%0d", i), 32'(ready_a), 32'(i == 16));
    end
    for (int a = 0; a < 16; a++)
      rd_a(4'(a), 4'(15 - a), 16'h0, 16'h0, $sformatf("clr_rd_%0d", a));

    we_a = 1'b1; dst_addr_a = 4'd5; dst_a = 16'hA5A5;
    rd_a(4'd5, 4'd0, 16'hA5A5, 16'h0, "bypass_r5");
    dst_addr_a = 4'd0; dst_a = 16'hFFFF;
    rd_a(4'd5, 4'd0, 16'hA5A5, 16'h0, "zero_reg_wr");
    we_a = 1'b0;

    re0_a = 1'b0; p0_addr_a = 4'd0;
    re1_a = 1'b1; p1_addr_a = 4'd5;
    push("hold_p0", 32'hA5A5);
    push("upd_p1", 32'hA5A5);
    tick();
    pop_chk(32'(p0_a));
    pop_chk(32'(p1_a));
    re1_a = 1'b0;

    we_a = 1'b1;
    for (int n = 1; n < 15; n++) begin
      dst_addr_a = 4'(n);
      dst_a = 16'(n * 16'h111);
      tick();
    end
    dst_addr_a = 4'd15; dst_a = 16'h0FFF; hlt_a = 1'b1;
    for (int n = 1; n < 16; n++) begin
      push($sformatf("dump_addr_%0d", n), 32'(n));
      push($sformatf("dump_data_%0d", n), 32'(n * 32'h111));
    end
    tick();
    chk("dump_latency", 32'(dump_valid_a), 32'h0);
    dst_addr_a = 4'd3; dst_a = 16'hDEAD;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("dump_valid_%0d", i), 32'(dump_valid_a), 32'h1);
      pop_chk(32'(dump_addr_a));
      pop_chk(32'(dump_data_a));
    end
    tick();
    chk("dump_end", 32'(dump_valid_a), 32'h0);

    dst_addr_a = 4'd4; dst_a = 16'hBEEF;
    rd_a(4'd4, 4'd3, 16'h0444, 16'h0333, "halted_wr");
    rd_a(4'd15, 4'd3, 16'h0FFF, 16'h0333, "halted_rd");
    chk("no_redump", 32'(dump_valid_a), 32'h0);
    chk("ready_halted", 32'(ready_a), 32'h1);
    we_a = 1'b0; hlt_a = 1'b0;
    tick();
    we_a = 1'b1; dst_addr_a = 4'd4; dst_a = 16'h1234;
    rd_a(4'd4, 4'd4, 16'h1234, 16'h1234, "run_again");
    we_a = 1'b0;

    hlt_a = 1'b1;
    tick();
    tick();
    chk("dump2_valid", 32'(dump_valid_a), 32'h1);
    chk("dump2_addr", 32'(dump_addr_a), 32'h1);
    rst_a = 1'b0;
    #1;
    chk("abort_valid", 32'(dump_valid_a), 32'h0);
    chk("abort_ready", 32'(ready_a), 32'h0);
    hlt_a = 1'b0;
    tick();
    tick();
    rst_a = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i >= 15)
        chk($sformatf("reclear_ready_%0d", i), 32'(ready_a), 32'(i == 16));
    end
    for (int a = 0; a < 16; a++)
      rd_a(4'(a), 4'(15 - a), 16'h0, 16'h0, $sformatf("reclr_rd_%0d", a));

    rst_b = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i >= 31)
        chk($sformatf("b_ready_%0d", i), 32'(ready_b), 32'(i == 32));
    end
    repeat (3) tick();
    chk("b_clear_hlt_ignored", 32'(dump_valid_b), 32'h0);
    hlt_b = 1'b0;
    tick();
    we_b = 1'b1; dst_addr_b = 5'd0; dst_b = 32'hCAFEF00D;
    rd_b(5'd0, 5'd0, 32'hCAFEF00D, 32'hCAFEF00D, "b_r0_bypass");
    for (int n = 1; n < 32; n++) begin
      dst_addr_b = 5'(n);
      dst_b = 32'h1000_0000 | 32'(n);
      if (n == 31) hlt_b = 1'b1;
      if (n == 31) begin
        re0_b = 1'b0;
        re1_b = 1'b0;
      end
      if (n < 31) tick();
    end
    for (int a = 0; a < 32; a++) begin
      push($sformatf("b_dump_addr_%0d", a), 32'(a));
      push($sformatf("b_dump_data_%0d", a),
           (a == 0) ? 32'hCAFEF00D : (32'h1000_0000 | 32'(a)));
    end
    tick();
    we_b = 1'b0;
    chk("b_dump_latency", 32'(dump_valid_b), 32'h0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk($sformatf("b_dump_valid_%0d", i), 32'(dump_valid_b), 32'h1);
      pop_chk(32'(dump_addr_b));
      pop_chk(dump_data_b);
    end
    tick();
    chk("b_dump_end", 32'(dump_valid_b), 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_param.md
# rf_param

Parametrised successor to the pipeline's triple-ported register file: WIDTH-bit × DEPTH-entry storage, two read ports, one write port, fully synchronous to `clk`. Adds registered reads with write-to-read bypass, a hardware clear sweep after reset, and a sequenced dump port driven by `hlt`. Sits in the decode stage (reads) and writeback stage (write) of the pipelined CPU.

## Interface
- WIDTH, 16, data width in bits
- DEPTH, 16, number of registers; power of two, ≥ 2
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary
- AW (localparam), $clog2(DEPTH), address width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_addr, p1_addr  in  AW  read addresses
- re0, re1  in  1  read enables
- p0, p1  out  WIDTH  registered read data
- dst_addr  in  AW  write address
- dst  in  WIDTH  write data
- we  in  1  write enable
- hlt  in  1  halt; rising edge starts a dump
- ready  out  1  clear sweep complete, file usable
- dump_valid  out  1  dump_addr/dump_data valid this cycle
- dump_addr  out  AW  register being dumped
- dump_data  out  WIDTH  contents of dump_addr

## Operation
- FSM states: CLEAR, RUN, DUMP, HALTED. rst_n low forces CLEAR, clear pointer 0, all outputs 0, hlt_q 0.
- CLEAR: one entry per cycle, mem[ptr] <= 0, ptr 0..DEPTH-1; after ptr = DEPTH-1 written → RUN, ready <= 1. Reads return 0, writes ignored.
- RUN: write accepted iff we && !(ZERO_REG && dst_addr == 0); mem[dst_addr] <= dst at rising edge.
- Read port k (k = 0, 1): if rek, pk <= (write accepted this cycle && dst_addr == pk_addr) ? dst : mem[pk_addr]; if !rek, pk holds. ZERO_REG && pk_addr == 0 → 0 regardless of bypass.
- hlt_q <= hlt every cycle, all states. Edge = hlt && !hlt_q.
- RUN with edge → DUMP, dump pointer = (ZERO_REG ? 1 : 0). Write in the edge cycle is still accepted.
- DUMP: each cycle dump_valid <= 1, dump_addr <= ptr, dump_data <= mem[ptr], ptr++; after ptr = DEPTH-1 → HALTED. Writes ignored; reads served (no bypass, since no write is accepted).
- HALTED: dump_valid 0; writes ignored, reads served; hlt low → RUN.
- Edge in CLEAR, DUMP, or HALTED: ignored. hlt held high through CLEAR produces no dump.
- Reset mid-DUMP or mid-CLEAR: immediate abort, restart at CLEAR, ptr 0; previous contents discarded.

## Timing
- Reset values: p0 = p1 = 0, ready = 0, dump_valid = 0, dump_addr = 0, dump_data = 0.
- Clear sweep: ready rises at the DEPTH-th rising edge after rst_n deasserts (the first edge writes entry 0).
- Read latency: 1 cycle; address at edge n, data on pk after edge n.
- Write visibility: same-cycle bypass; a read in cycle n+1 sees mem directly.
- Dump: edge sampled at edge n → first dump_valid after edge n+1; DEPTH-ZERO_REG consecutive valid cycles, no gaps; HALTED on the next edge after the last.
- ready stays 1 through DUMP and HALTED; it is cleared only by reset.

## Test plan
- Reset, hold rst_n low, release → ready = 0 for 15 cycles, then 1 (DEPTH = 16); read every address → 0.
- RUN: write R5 = 16'hA5A5 with re0 and p0_addr = 5 in the same cycle → p0 = A5A5 next cycle (bypass); write R0 = FFFF with ZERO_REG = 1 → p1 reading R0 = 0000.
- re0 low while p0_addr changes → p0 holds its last value; re1 high on the same cycle → p1 updates normally.
- Load Rn = n*0x111 for n = 1..15, raise hlt → 15 consecutive dump_valid cycles, addr 1..F, data 0111..0FFF. A write during the dump is ignored; a second hlt edge while HALTED is ignored. Drop hlt → RUN.
- Pulse rst_n low mid-dump → dump_valid drops immediately; CLEAR sweep restarts; all registers read 0 after ready.
- DEPTH = 32, WIDTH = 32, ZERO_REG = 0 → R0 writable; dump covers addr 0..31; ready after 32 cycles.
